sseg4_tdm_capture: RTL and testbench

//  Receive side of the 4-digit TDM seven-segment interface. Watches the multiplexed
//  seg/dp/an lines driven by sseg4_TDM, decodes each strobed digit back to a nibble,
//  and assembles a full 4-digit frame. Used for loopback self-check on the board and
//  as a bench monitor. Same clock domain as the display driver.

---
 rtl/sseg4_tdm_capture.sv | 200 ++++++++++++++++++++
 tb/tb_sseg4_tdm_capture.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg4_tdm_capture.sv
// Receive side of the 4-digit TDM seven-segment bus: captures each settled digit and
// assembles a 4-digit frame (data, blank/minus/dp masks, err), with a no-capture stall watchdog.
module sseg4_tdm_capture #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  seg,
  input  logic        dp,
  input  logic [3:0]  an,
  output logic [15:0] data,
  output logic [3:0]  blank_mask,
  output logic [3:0]  minus_mask,
  output logic [3:0]  dp_mask,
  output logic        err,
  output logic        frame_valid,
  output logic        stalled
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [3:0]      r_an_prev, w_an_prev_nxt;
  logic [TW-1:0]   r_idle;
  logic [3:0]      r_seen;

  logic [15:0]     r_nib;
  logic [3:0]      r_blank, r_minus, r_dp, r_bad;
  logic [15:0]     r_data;
  logic [3:0]      r_blank_mask, r_minus_mask, r_dp_mask;
  logic            r_err, r_frame_valid, r_stalled;

  logic            w_an_valid;
  logic [1:0]      w_idx;
  logic [3:0]      w_nib;
  logic            w_blank, w_minus, w_bad;
  logic            w_restart, w_capture, w_frame;
  logic [3:0]      w_seen_nxt;
  logic [15:0]     w_nib_all;
  logic [3:0]      w_blank_all, w_minus_all, w_dp_all, w_bad_all;

  always_comb begin
    w_an_valid = 1'b1;
    w_idx      = 2'd0;
    case (an)
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_an_valid = 1'b0;
    endcase
  end

  // Active-low segment patterns back to nibbles; blank and minus are legal non-digits.
  always_comb begin
    w_nib   = 4'h0;
    w_blank = 1'b0;
    w_minus = 1'b0;
    w_bad   = 1'b0;
    case (seg)
      7'h40: w_nib = 4'h0;
      7'h79: w_nib = 4'h1;
      7'h24: w_nib = 4'h2;
      7'h30: w_nib = 4'h3;
      7'h19: w_nib = 4'h4;
      7'h12: w_nib = 4'h5;
      7'h02: w_nib = 4'h6;
      7'h78: w_nib = 4'h7;
      7'h00: w_nib = 4'h8;
      7'h10: w_nib = 4'h9;
      7'h08: w_nib = 4'hA;
      7'h03: w_nib = 4'hB;
      7'h46: w_nib = 4'hC;
      7'h21: w_nib = 4'hD;
      7'h06: w_nib = 4'hE;
      7'h0E: w_nib = 4'hF;
      7'h7F: w_blank = 1'b1;
      7'h3F: w_minus = 1'b1;
      default: w_bad = 1'b1;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_an_prev_nxt = r_an_prev;
    w_capture     = 1'b0;
    w_restart     = (r_state == S_IDLE) || (an != r_an_prev);
    if (w_restart) begin
      if (w_an_valid) begin
        w_an_prev_nxt = an;
        if (SETTLE_CYCLES == 1) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HOLD;
        end else begin
          w_cnt_nxt   = CW'(1);
          w_state_nxt = S_SETTLE;
        end
      end else begin
        w_state_nxt = S_IDLE;
      end
    end else if (r_state == S_SETTLE) begin
      if (r_cnt == CW'(SETTLE_CYCLES - 1)) begin
        w_capture   = 1'b1;
        w_state_nxt = S_HOLD;
      end else begin
        w_cnt_nxt = r_cnt + CW'(1);
      end
    end
  end

  // Slot contents as they will be after this capture; also what a completing frame loads.
  always_comb begin
    w_nib_all                   = r_nib;
    w_blank_all                 = r_blank;
    w_minus_all                 = r_minus;
    w_dp_all                    = r_dp;
    w_bad_all                   = r_bad;
    w_nib_all[{w_idx, 2'b00} +: 4] = w_nib;
    w_blank_all[w_idx]          = w_blank;
    w_minus_all[w_idx]          = w_minus;
    w_dp_all[w_idx]             = ~dp;
    w_bad_all[w_idx]            = w_bad;
    w_seen_nxt                  = r_seen | (4'b0001 << w_idx);
    w_frame                     = w_capture && (w_seen_nxt == 4'hF);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_an_prev <= 4'hF;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_an_prev <= w_an_prev_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_idle        <= '0;
      r_seen        <= 4'h0;
      r_nib         <= '0;
      r_blank       <= '0;
      r_minus       <= '0;
      r_dp          <= '0;
      r_bad         <= '0;
      r_data        <= '0;
      r_blank_mask  <= '0;
      r_minus_mask  <= '0;
      r_dp_mask     <= '0;
      r_err         <= 1'b0;
      r_frame_valid <= 1'b0;
      r_stalled     <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      if (w_capture) begin
        r_nib     <= w_nib_all;
        r_blank   <= w_blank_all;
        r_minus   <= w_minus_all;
        r_dp      <= w_dp_all;
        r_bad     <= w_bad_all;
        r_idle    <= '0;
        r_stalled <= 1'b0;
        if (w_frame) begin
          r_data        <= w_nib_all;
          r_blank_mask  <= w_blank_all;
          r_minus_mask  <= w_minus_all;
          r_dp_mask     <= w_dp_all;
          r_err         <= |w_bad_all;
          r_frame_valid <= 1'b1;
          r_seen        <= 4'h0;
        end else begin
          r_seen <= w_seen_nxt;
        end
      end else if (r_idle != TW'(TIMEOUT_CYCLES)) begin
        r_idle <= r_idle + TW'(1);
        if (r_idle == TW'(TIMEOUT_CYCLES - 1)) begin
          r_stalled <= 1'b1;
          r_seen    <= 4'h0;
        end
      end
    end
  end

  assign data        = r_data;
  assign blank_mask  = r_blank_mask;
  assign minus_mask  = r_minus_mask;
  assign dp_mask     = r_dp_mask;
  assign err         = r_err;
  assign frame_valid = r_frame_valid;
  assign stalled     = r_stalled;

endmodule

// File: tb/tb_sseg4_tdm_capture.sv
// Bench for sseg4_tdm_capture: table-driven frames, hand-written corner sequences and a
// randomized scan checked cycle-by-cycle against a run-length reference model.
module tb_sseg4_tdm_capture;

  localparam int SETTLE = 4;
  localparam int TMO    = 100;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  seg   = 7'h7F;
  logic        dp    = 1'b1;
  logic [3:0]  an    = 4'hF;
  logic [15:0] data;
  logic [3:0]  blank_mask, minus_mask, dp_mask;
  logic        err, frame_valid, stalled;

  sseg4_tdm_capture #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .seg(seg), .dp(dp), .an(an),
    .data(data), .blank_mask(blank_mask), .minus_mask(minus_mask), .dp_mask(dp_mask),
    .err(err), .frame_valid(frame_valid), .stalled(stalled)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int fv_cnt   = 0;
  int fv_step  = 0;

  logic [6:0] seg_code [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: a digit is captured on the SETTLE-th consecutive cycle of a valid an value.
  bit          m_have_prev;
  logic [3:0]  m_prev;
  int          m_run;
  int          m_idle;
  logic [3:0]  m_seen;
  logic [3:0]  sl_nib [4];
  logic        sl_b [4], sl_m [4], sl_d [4], sl_bad [4];
  logic [15:0] m_data;
  logic [3:0]  m_blank, m_minus, m_dp;
  logic        m_err, m_fv, m_stalled;

  typedef struct {
    logic [27:0] segs;
    logic [3:0]  dpn;
    logic [15:0] exp_data;
    logic [3:0]  exp_blank, exp_minus, exp_dp;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int an_index(input logic [3:0] a);
    for (int i = 0; i < 4; i++)
      if (a == ~(4'b0001 << i)) return i;
    return -1;
  endfunction

  task automatic tb_decode(input logic [6:0] s, output logic [3:0] n, output logic b,
                           output logic m, output logic bad);
    n = 4'h0; b = 1'b0; m = 1'b0; bad = 1'b1;
    if (s == 7'h7F) begin b = 1'b1; bad = 1'b0; end
    else if (s == 7'h3F) begin m = 1'b1; bad = 1'b0; end
    else
      for (int k = 0; k < 16; k++)
        if (seg_code[k] == s) begin n = 4'(k); bad = 1'b0; end
  endtask

  task automatic model_reset();
    m_have_prev = 0; m_prev = 4'hF; m_run = 0; m_idle = 0; m_seen = 4'h0;
    for (int i = 0; i < 4; i++) begin
      sl_nib[i] = 4'h0; sl_b[i] = 0; sl_m[i] = 0; sl_d[i] = 0; sl_bad[i] = 0;
    end
    m_data = 16'h0; m_blank = 4'h0; m_minus = 4'h0; m_dp = 4'h0;
    m_err = 0; m_fv = 0; m_stalled = 0;
  endtask

  task automatic model_edge(input logic [3:0] a, input logic [6:0] s, input logic d);
    int idx;
    m_fv = 0;
    if (m_have_prev && a == m_prev) m_run++;
    else begin m_run = 1; m_prev = a; m_have_prev = 1; end
    idx = an_index(a);
    if (idx >= 0 && m_run == SETTLE) begin
      tb_decode(s, sl_nib[idx], sl_b[idx], sl_m[idx], sl_bad[idx]);
      sl_d[idx] = ~d;
      m_seen[idx] = 1'b1;
      m_idle = 0;
      m_stalled = 0;
      if (m_seen == 4'hF) begin
        for (int i = 0; i < 4; i++) begin
          m_data[4*i +: 4] = sl_nib[i];
          m_blank[i] = sl_b[i]; m_minus[i] = sl_m[i]; m_dp[i] = sl_d[i];
        end
        m_err  = sl_bad[0] | sl_bad[1] | sl_bad[2] | sl_bad[3];
        m_seen = 4'h0;
        m_fv   = 1;
      end
    end else if (m_idle < TMO) begin
      m_idle++;
      if (m_idle == TMO) begin m_stalled = 1; m_seen = 4'h0; end
    end
  endtask

  task automatic compare_all();
    check("data", data, m_data);
    check("blank_mask", 16'(blank_mask), 16'(m_blank));
    check("minus_mask", 16'(minus_mask), 16'(m_minus));
    check("dp_mask", 16'(dp_mask), 16'(m_dp));
    check("err", 16'(err), 16'(m_err));
    check("frame_valid", 16'(frame_valid), 16'(m_fv));
    check("stalled", 16'(stalled), 16'(m_stalled));
  endtask

  task automatic step(input logic [3:0] a, input logic [6:0] s, input logic d);
    an = a; seg = s; dp = d;
    @(posedge clock);
    model_edge(a, s, d);
    #1;
    compare_all();
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
    fv_step = 0;
    for (int k = 1; k <= n; k++) begin
      step(a, s, d);
      if (frame_valid) begin fv_cnt++; fv_step = k; end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"}, data, 16'h0);
    check({tag, "_masks"}, {4'h0, blank_mask, minus_mask, dp_mask}, 16'h0);
    check({tag, "_flags"}, {13'h0, err, frame_valid, stalled}, 16'h0);
  endtask

  // Entered just after a sampling point; reset is asserted and released between edges.
  task automatic mid_reset();
    #2 reset = 1'b0;
    #1 check_zero("async_reset");
    model_reset();
    #2 reset = 1'b1;
  endtask

  task automatic scan(input logic [27:0] segs, input logic [3:0] dpn, input int dwell);
    for (int i = 0; i < 4; i++)
      hold(~(4'b0001 << i), segs[7*i +: 7], dpn[i], dwell);
  endtask

  vec_t vecs [4];

  initial begin
    vecs[0] = '{segs: {7'h40, 7'h79, 7'h08, 7'h03}, dpn: 4'hF, exp_data: 16'h01AB,
                exp_blank: 4'h0, exp_minus: 4'h0, exp_dp: 4'h0, exp_err: 1'b0};
    vecs[1] = '{segs: {7'h3F, 7'h7F, 7'h21, 7'h46}, dpn: 4'b1101, exp_data: 16'h00DC,
                exp_blank: 4'h4, exp_minus: 4'h8, exp_dp: 4'h2, exp_err: 1'b0};
    vecs[2] = '{segs: {7'h0E, 7'h02, 7'h12, 7'h55}, dpn: 4'hF, exp_data: 16'hF650,
                exp_blank: 4'h0, exp_minus: 4'h0, exp_dp: 4'h0, exp_err: 1'b1};
    vecs[3] = '{segs: {7'h30, 7'h19, 7'h06, 7'h10}, dpn: 4'b0110, exp_data: 16'h34E9,
                exp_blank: 4'h0, exp_minus: 4'h0, exp_dp: 4'h9, exp_err: 1'b0};

    model_reset();
    for (int i = 0; i < 5; i++) begin
      an = 4'($urandom); seg = 7'($urandom); dp = 1'($urandom);
      @(posedge clock);
      #1 check_zero("reset_hold");
    end
    #2 reset = 1'b1;
    fv_cnt = 0;
    hold(4'hF, 7'h7F, 1'b1, 50);
    check("idle_no_frame", 16'(fv_cnt), 16'd0);

    for (int v = 0; v < 4; v++) begin
      fv_cnt = 0;
      scan(vecs[v].segs, vecs[v].dpn, 8);
      check("tbl_fv_count", 16'(fv_cnt), 16'd1);
      check("tbl_fv_latency", 16'(fv_step), 16'd4);
      check("tbl_data", data, vecs[v].exp_data);
      check("tbl_blank", 16'(blank_mask), 16'(vecs[v].exp_blank));
      check("tbl_minus", 16'(minus_mask), 16'(vecs[v].exp_minus));
      check("tbl_dp", 16'(dp_mask), 16'(vecs[v].exp_dp));
      check("tbl_err", 16'(err), 16'(vecs[v].exp_err));
    end

    // Short an glitch must not capture slot 1.
    fv_cnt = 0;
    hold(4'b1110, 7'h40, 1'b1, 8);
    hold(4'b1101, 7'h55, 1'b1, 2);
    hold(4'b1011, 7'h30, 1'b1, 8);
    hold(4'b0111, 7'h78, 1'b1, 8);
    check("glitch_no_frame", 16'(fv_cnt), 16'd0);
    hold(4'b1101, 7'h24, 1'b1, 8);
    check("glitch_frame_count", 16'(fv_cnt), 16'd1);
    check("glitch_data", data, 16'h7320);
    check("glitch_err", 16'(err), 16'd0);

    // Stall discards the partial frame; stalled clears on the next capture.
    fv_cnt = 0;
    hold(4'b1110, 7'h12, 1'b1, 4);
    hold(4'b1101, 7'h02, 1'b1, 4);
    hold(4'hF, 7'h7F, 1'b1, TMO - 1);
    check("stall_before_timeout", 16'(stalled), 16'd0);
    hold(4'hF, 7'h7F, 1'b1, 1);
    check("stall_at_timeout", 16'(stalled), 16'd1);
    hold(4'b1011, 7'h19, 1'b1, 3);
    check("stall_before_capture", 16'(stalled), 16'd1);
    hold(4'b1011, 7'h19, 1'b1, 1);
    check("stall_cleared", 16'(stalled), 16'd0);
    hold(4'b0111, 7'h10, 1'b1, 8);
    check("stall_seen_cleared", 16'(fv_cnt), 16'd0);
    hold(4'b1110, 7'h46, 1'b1, 8);
    hold(4'b1101, 7'h0E, 1'b1, 8);
    check("stall_frame_count", 16'(fv_cnt), 16'd1);
    check("stall_data", data, 16'h94FC);

    // Reset mid-frame loses the partial frame.
    fv_cnt = 0;
    hold(4'b1110, 7'h40, 1'b0, 8);
    hold(4'b1101, 7'h79, 1'b1, 3);
    mid_reset();
    hold(4'b1011, 7'h79, 1'b1, 8);
    hold(4'b0111, 7'h79, 1'b1, 8);
    hold(4'b1101, 7'h79, 1'b1, 8);
    check("reset_partial_lost", 16'(fv_cnt), 16'd0);

    for (int n = 0; n < 300; n++) begin
      logic [3:0] a;
      logic [6:0] s;
      int r, dwell;
      r = $urandom_range(0, 99);
      if (r < 85) a = ~(4'b0001 << $urandom_range(0, 3));
      else begin
        a = 4'($urandom);
        while (an_index(a) >= 0) a = 4'($urandom);
      end
      r = $urandom_range(0, 99);
      if (r < 70) s = seg_code[$urandom_range(0, 15)];
      else if (r < 80) s = 7'h7F;
      else if (r < 90) s = 7'h3F;
      else s = 7'($urandom);
      dwell = $urandom_range(1, 10);
      if (an_index(a) < 0 && $urandom_range(0, 99) < 4) dwell = TMO + 10;
      hold(a, s, 1'($urandom), dwell);
      if (n == 150) mid_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
